// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter
//   Shares one AXI read channel (AR/R) between the instruction-cache and
//   data-cache refill paths. The arbiter grants one requester, issues one
//   burst for it, assembles the returned beats into a full cache line, and
//   returns that line with a one-cycle valid pulse.
//
// Optional build macro:
//   CRITICAL_WORD_FIRST_EN - issue a WRAP burst starting at the missed word.
//                            Beats are placed at wrapped word indices.
//                            Without it, bursts are line-aligned INCR bursts
//                            starting at word 0.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid[1:0]      refill requests (bit1 icache, bit0 dcache), held until resp_valid
//   req_addr_i/_d       miss addresses of the icache / dcache
//   req_grant[1:0]      one-hot pulse on the AR handshake for the grantee
//   resp_valid[1:0]     one-hot pulse, line ready for the grantee
//   resp_err            error flag, qualified by resp_valid
//   resp_line           assembled line, stable until the next fill begins
//   busy                FSM not idle
//   m_axi_ar*           AXI read-address channel (master side)
//   m_axi_r*            AXI read-data channel (master side)

module line_fill_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  req_valid,
  input  logic [ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [ADDR_WIDTH-1:0]       req_addr_d,
  output logic [1:0]                  req_grant,
  output logic [1:0]                  resp_valid,
  output logic                        resp_err,
  output logic [BEATS*DATA_WIDTH-1:0] resp_line,
  output logic                        busy,
  output logic [ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int LINE_W   = BEATS * DATA_WIDTH;
  localparam int IW       = $clog2(BEATS);           // word index width
  localparam int CW       = IW + 1;                  // beat count must reach BEATS
  localparam int LINE_OFF = $clog2(LINE_W / 8);
  localparam int WORD_OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [CW-1:0] CNT_FULL = CW'(BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

`ifdef CRITICAL_WORD_FIRST_EN
  localparam int         ALIGN = WORD_OFF;
  localparam logic [1:0] BURST = 2'b10;  // WRAP
`else
  localparam int         ALIGN = LINE_OFF;
  localparam logic [1:0] BURST = 2'b01;  // INCR
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ALIGN;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                              state_q, state_d;
  logic                                gnt_q;         // 1 = icache, 0 = dcache
  logic                                last_grant_q;
  logic                                err_q;
  logic [ADDR_WIDTH-1:0]               addr_q;
  logic [CW-1:0]                       cnt_q;         // beats accepted so far
  logic [IW-1:0]                       start_q;       // word index of the first beat
  logic [BEATS-1:0][DATA_WIDTH-1:0]    line_q;

  logic                  gnt_sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [IW-1:0]         sel_start;
  logic [IW-1:0]         wr_idx;
  logic                  beat_hit;
  logic                  beat_store;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    unique case (req_valid)
      2'b10:   gnt_sel = 1'b1;
      2'b01:   gnt_sel = 1'b0;
      default: gnt_sel = ~last_grant_q;
    endcase
  end

  assign sel_addr = gnt_sel ? req_addr_i : req_addr_d;
`ifdef CRITICAL_WORD_FIRST_EN
  assign sel_start = sel_addr[LINE_OFF-1:WORD_OFF];
`else
  assign sel_start = '0;
`endif

  // IW-bit add wraps modulo BEATS, which is what a WRAP burst needs.
  assign wr_idx     = start_q + cnt_q[IW-1:0];
  assign beat_hit   = (state_q == DATA) && m_axi_rvalid && (m_axi_rid == m_axi_arid);
  // Matching beats beyond BEATS are consumed but not stored.
  assign beat_store = beat_hit && (cnt_q != CNT_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    m_axi_arvalid = 1'b0;
    req_grant     = 2'b00;
    resp_valid    = 2'b00;
    resp_err      = 1'b0;
    unique case (state_q)
      IDLE: if (|req_valid) state_d = ADDR;
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          req_grant[gnt_q] = 1'b1;
          state_d          = DATA;
        end
      end
      DATA: if (beat_hit && m_axi_rlast) state_d = RESP;
      RESP: begin
        // A requester that gave up gets nothing; the line is dropped silently.
        resp_valid[gnt_q] = req_valid[gnt_q];
        resp_err          = err_q && req_valid[gnt_q];
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;  // icache, so the first tie goes to the dcache
      err_q        <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      start_q      <= '0;
      // NOTE: the line buffer is plain flops driven straight to the port, so
      // it is reset to a defined value rather than left as unreset storage.
      line_q       <= '0;
    end else begin
      if (state_q == IDLE && |req_valid) begin
        gnt_q   <= gnt_sel;
        addr_q  <= sel_addr & ADDR_MASK;
        start_q <= sel_start;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == ADDR && m_axi_arready) last_grant_q <= gnt_q;
      if (beat_store) begin
        line_q[wr_idx] <= m_axi_rdata;
        cnt_q          <= cnt_q + 1'b1;
        if (m_axi_rresp != 2'b00) err_q <= 1'b1;
      end
      // Length check is on beats accepted, so it also holds for wrapped bursts.
      if (beat_hit && m_axi_rlast && cnt_q != CNT_LAST) err_q <= 1'b1;
    end
  end

  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, gnt_q};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(WORD_OFF);
  assign m_axi_arburst = BURST;
  assign m_axi_rready  = 1'b1;  // always drains, including stray beats
  assign busy          = (state_q != IDLE);
  assign resp_line     = line_q;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Self-checking bench for line_fill_arbiter with default parameters.
// Table-driven fills, plus directed sequences for these cases:
//   - error responses and stray IDs
//   - early and late rlast
//   - a dropped requester
//   - reset in the middle of a burst

module tb_line_fill_arbiter;

  localparam int BEATS = 8;
  localparam int DW    = 64;
  localparam int LW    = BEATS * DW;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam logic [1:0] EXP_BURST = CWF ? 2'b10 : 2'b01;

  typedef logic [LW-1:0] wide_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [63:0]       req_addr_i, req_addr_d;
  logic [1:0]        req_grant, resp_valid;
  logic              resp_err, busy;
  logic [LW-1:0]     resp_line;
  logic [12:0]       m_axi_arid, m_axi_rid;
  logic [63:0]       m_axi_araddr, m_axi_rdata;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst, m_axi_rresp;
  logic              m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  line_fill_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr_i(req_addr_i), .req_addr_d(req_addr_d),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_line(resp_line), .busy(busy),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BEATS-1:0][DW-1:0] exp_line;

  typedef struct {
    logic [1:0]  req;
    logic [63:0] ai;
    logic [63:0] ad;
    logic        exp_idx;
    logic [63:0] seed;
    int          stall;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_araddr(input logic [63:0] a);
    return CWF ? (a & ~64'h7) : (a & ~64'h3F);
  endfunction

  function automatic int word_pos(input logic [63:0] a, input int b);
    return CWF ? ((int'(a[5:3]) + b) % BEATS) : b;
  endfunction

  // Presents one R beat for exactly one rising edge; returns at the next negedge.
  task automatic beat(input logic [12:0] id, input logic [63:0] data,
                      input logic [1:0] resp, input logic last);
    m_axi_rvalid = 1'b1;
    m_axi_rid    = id;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    m_axi_rlast  = last;
    @(negedge clk);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  // Raise a request and let the AR handshake complete immediately; returns in DATA.
  task automatic issue(input logic [1:0] req, input logic [63:0] ai, input logic [63:0] ad);
    req_valid     = req;
    req_addr_i    = ai;
    req_addr_d    = ad;
    m_axi_arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_axi_arready = 1'b0;
  endtask

  // Full, well-formed fill with arready held low for 'stall' ADDR cycles.
  task automatic do_fill(input logic [1:0] req, input logic [63:0] ai, input logic [63:0] ad,
                         input logic exp_idx, input logic [63:0] seed, input int stall,
                         input string tag);
    logic [63:0] a;
    logic [1:0]  oh;
    logic [12:0] id;
    logic [63:0] a0;
    a  = exp_idx ? ai : ad;
    oh = exp_idx ? 2'b10 : 2'b01;
    id = {12'b0, exp_idx};
    // IDLE cycle: request becomes visible
    req_valid = req; req_addr_i = ai; req_addr_d = ad; m_axi_arready = 1'b0;
    #1 check({tag, "_idle_busy"}, wide_t'(busy), wide_t'(1'b0));
    @(negedge clk);
    a0 = m_axi_araddr;
    for (int s = 0; s <= stall; s++) begin
      m_axi_arready = (s == stall);
      #1;
      check({tag, "_arvalid"}, wide_t'(m_axi_arvalid), wide_t'(1'b1));
      check({tag, "_araddr"}, wide_t'(m_axi_araddr), wide_t'(exp_araddr(a)));
      check({tag, "_grant"}, wide_t'(req_grant), wide_t'((s == stall) ? oh : 2'b00));
      if (s == stall) begin
        check({tag, "_arid"}, wide_t'(m_axi_arid), wide_t'(id));
        check({tag, "_arlen"}, wide_t'(m_axi_arlen), wide_t'(8'd7));
        check({tag, "_arsize"}, wide_t'(m_axi_arsize), wide_t'(3'd3));
        check({tag, "_arburst"}, wide_t'(m_axi_arburst), wide_t'(EXP_BURST));
        if (stall > 0) check({tag, "_araddr_stable"}, wide_t'(m_axi_araddr), wide_t'(a0));
      end
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      exp_line[word_pos(a, b)] = seed * 64'(b + 1);
      if (b == BEATS - 1) begin
        #1 check({tag, "_no_early_resp"}, wide_t'(resp_valid), wide_t'(2'b00));
        check({tag, "_rready"}, wide_t'(m_axi_rready), wide_t'(1'b1));
      end
      beat(id, seed * 64'(b + 1), 2'b00, b == BEATS - 1);
    end
    #1;
    check({tag, "_resp_valid"}, wide_t'(resp_valid), wide_t'(oh));
    check({tag, "_resp_err"}, wide_t'(resp_err), wide_t'(1'b0));
    check({tag, "_line"}, wide_t'(resp_line), wide_t'(exp_line));
    @(negedge clk);
    req_valid = 2'b00;
    #1 check({tag, "_done_busy"}, wide_t'(busy), wide_t'(1'b0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ties first: dcache, icache, dcache
    tbl[0] = '{2'b11, 64'h1_0084, 64'h2_00F8, 1'b0, 64'h100, 0};
    tbl[1] = '{2'b11, 64'h1_0084, 64'h2_00F8, 1'b1, 64'h200, 0};
    tbl[2] = '{2'b11, 64'h1_0084, 64'h2_00F8, 1'b0, 64'h300, 0};
    tbl[3] = '{2'b01, 64'h0, 64'h8000_1238, 1'b0, 64'h11, 0};
    tbl[4] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFC7, 64'h0, 1'b1, 64'h400, 5};
    tbl[5] = '{2'b10, 64'h1234_5678_9ABC_DE3F, 64'h0, 1'b1, 64'h500, 0};
    tbl[6] = '{2'b11, 64'h9000, 64'hA040, 1'b0, 64'h600, 0};
    tbl[7] = '{2'b01, 64'h0, 64'h1028, 1'b0, 64'h700, 0};

    reset = 1'b1; req_valid = 2'b00; req_addr_i = '0; req_addr_d = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    exp_line = '0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_busy", wide_t'(busy), wide_t'(1'b0));
    check("rst_arvalid", wide_t'(m_axi_arvalid), wide_t'(1'b0));
    check("rst_grant", wide_t'(req_grant), wide_t'(2'b00));
    check("rst_resp_valid", wide_t'(resp_valid), wide_t'(2'b00));
    check("rst_resp_err", wide_t'(resp_err), wide_t'(1'b0));
    check("rst_line", wide_t'(resp_line), wide_t'(0));
    check("rst_rready", wide_t'(m_axi_rready), wide_t'(1'b1));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_fill(tbl[i].req, tbl[i].ai, tbl[i].ad, tbl[i].exp_idx, tbl[i].seed,
              tbl[i].stall, $sformatf("vec%0d", i));

    // Error response on beat 3 plus a stray-ID beat that must not be stored
    issue(2'b01, 64'h0, 64'h3000);
    for (int b = 0; b < BEATS; b++) begin
      if (b == 2) beat(13'd5, 64'hDEAD_BEEF, 2'b00, 1'b0);
      exp_line[b] = 64'hB0 + 64'(b);
      beat(13'd0, 64'hB0 + 64'(b), (b == 3) ? 2'b10 : 2'b00, b == BEATS - 1);
    end
    #1;
    check("slverr_resp_valid", wide_t'(resp_valid), wide_t'(2'b01));
    check("slverr_resp_err", wide_t'(resp_err), wide_t'(1'b1));
    check("slverr_line", wide_t'(resp_line), wide_t'(exp_line));
    @(negedge clk); req_valid = 2'b00;

    // Early rlast after 4 beats: words 4..7 keep their prior contents
    issue(2'b01, 64'h0, 64'h4000);
    for (int b = 0; b < 4; b++) begin
      exp_line[b] = 64'hC0 + 64'(b);
      beat(13'd0, 64'hC0 + 64'(b), 2'b00, b == 3);
    end
    #1;
    check("early_resp_valid", wide_t'(resp_valid), wide_t'(2'b01));
    check("early_resp_err", wide_t'(resp_err), wide_t'(1'b1));
    check("early_line", wide_t'(resp_line), wide_t'(exp_line));
    @(negedge clk); req_valid = 2'b00;

    // Late rlast on the 10th beat: beats 8 and 9 are dropped
    issue(2'b01, 64'h0, 64'h5000);
    for (int b = 0; b < 10; b++) begin
      if (b < BEATS) exp_line[b] = 64'hD0 + 64'(b);
      beat(13'd0, 64'hD0 + 64'(b), 2'b00, b == 9);
    end
    #1;
    check("late_resp_valid", wide_t'(resp_valid), wide_t'(2'b01));
    check("late_resp_err", wide_t'(resp_err), wide_t'(1'b1));
    check("late_line", wide_t'(resp_line), wide_t'(exp_line));
    @(negedge clk); req_valid = 2'b00;

    // Icache drops its request mid-burst: burst completes, no response pulse
    issue(2'b10, 64'h6000, 64'h0);
    for (int b = 0; b < BEATS; b++) begin
      if (b == 2) req_valid = 2'b00;
      beat(13'd1, 64'hE0 + 64'(b), 2'b00, b == BEATS - 1);
    end
    #1;
    check("drop_resp_valid", wide_t'(resp_valid), wide_t'(2'b00));
    check("drop_resp_err", wide_t'(resp_err), wide_t'(1'b0));
    check("drop_busy_resp", wide_t'(busy), wide_t'(1'b1));
    @(negedge clk);
    #1 check("drop_busy_idle", wide_t'(busy), wide_t'(1'b0));

    // Reset with 4 beats stored; remaining beats are drained and ignored
    issue(2'b01, 64'h0, 64'h7000);
    for (int b = 0; b < 4; b++) beat(13'd0, 64'hF0 + 64'(b), 2'b00, 1'b0);
    req_valid = 2'b00;
    reset = 1'b1;
    beat(13'd0, 64'hF4, 2'b00, 1'b0);
    reset = 1'b0;
    #1;
    check("mrst_busy", wide_t'(busy), wide_t'(1'b0));
    check("mrst_arvalid", wide_t'(m_axi_arvalid), wide_t'(1'b0));
    check("mrst_line", wide_t'(resp_line), wide_t'(0));
    check("mrst_rready", wide_t'(m_axi_rready), wide_t'(1'b1));
    for (int b = 5; b < BEATS; b++) begin
      beat(13'd0, 64'hF0 + 64'(b), 2'b00, b == BEATS - 1);
      #1;
      check($sformatf("mrst_drain%0d_resp", b), wide_t'(resp_valid), wide_t'(2'b00));
      check($sformatf("mrst_drain%0d_busy", b), wide_t'(busy), wide_t'(1'b0));
    end
    @(negedge clk);
    exp_line = '0;
    do_fill(2'b01, 64'h0, 64'h8000_1238, 1'b0, 64'h21, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
